beta_mem_arbiter: RTL and testbench
===================================

# beta_mem_arbiter

Two-requester arbiter that shares one single-port, variable-latency memory between the Beta instruction-fetch path (IAdr/D) and the data path (Adr/WD/RD with MOE/MWR). It sits between the Beta core and main memory. It serialises accesses through a three-state FSM with a per-request handshake and round-robin tie-breaking. It drives a stall to the core while either requester is still waiting.

## Interface
- AW, 32, address width
- DW, 32, data width
- TIMEOUT, 15, max cycles in ACC waiting for mem_ack before error (only with timeout compiled in)
- clk  in  1  rising-edge clock
- RESET_N  in  1  asynchronous, active-low reset
- i_req  in  1  fetch request; level, held until i_ack
- i_adr  in  AW  fetch address
- i_ack  out  1  one-cycle pulse: fetch complete
- i_rdata  out  DW  fetched word, valid with i_ack, held until next i_ack
- d_req  in  1  data request (MOE|MWR); level, held until d_ack
- d_adr  in  AW  data address
- d_we  in  1  1 = write (MWR), 0 = read (MOE)
- d_wdata  in  DW  write data
- d_ack  out  1  one-cycle pulse: data access complete
- d_rdata  out  DW  read data, valid with d_ack, held until next d_ack
- err  out  1  with d_ack/i_ack: access timed out
- mem_req  out  1  memory request, held until mem_ack
- mem_adr  out  AW  registered address
- mem_we  out  1  registered write enable
- mem_wdata  out  DW  registered write data
- mem_ack  in  1  memory completion, single-cycle
- mem_rdata  in  DW  read data, valid with mem_ack
- stall  out  1  (i_req & ~i_ack) | (d_req & ~d_ack), combinational

## Operation
- States: IDLE, ACC, DONE. owner register (FETCH/DATA); last register = last granted owner.
- IDLE: the request state decides the grant.
  - Neither requests: stay in IDLE.
  - Only one requests: grant it.
  - Both request: grant the one ≠ last.
  - On grant: latch mem_adr/mem_we/mem_wdata, set owner and last, go to ACC. Fetch grant forces mem_we=0 and mem_wdata=0.
- ACC: mem_req=1.
  - On mem_ack: capture mem_rdata into i_rdata or d_rdata (per owner), err=0, go to DONE.
  - Writes also capture into d_rdata (memory's value, ignored by core).
- DONE: mem_req=0. The owner's ack is 1 for exactly this cycle, then go to IDLE.
  - Requester must drop or refresh its req at the edge ending DONE; a req still high in IDLE is a new access.
- The arbiter never re-arbitrates mid-access; a request arriving during ACC/DONE waits.
- A requester changing adr/data while req is high and un-acked is illegal; latched values are used.
- Reset (async, any state): state=IDLE, last=DATA (first tie goes to fetch), owner=FETCH.
  - All outputs 0: mem_req, mem_we, mem_adr, mem_wdata, i_ack, d_ack, err, i_rdata, d_rdata.
  - mem_req drops immediately on RESET_N low; an in-flight memory access is abandoned.

## Timing
- Request sampled high at edge of cycle N (IDLE): mem_req=1 from cycle N+1.
- mem_ack in cycle M: ack pulse in cycle M+1, rdata valid the same cycle.
- Minimum latency req→ack is 3 cycles (mem_ack in first ACC cycle). Back-to-back throughput is one access per 3 cycles plus memory wait.
- All outputs are registered except stall.

## Configuration
- BETA_ARB_TIMEOUT_EN defined: a 4+-bit wait counter clears on entry to ACC and increments each ACC cycle without mem_ack.
  - On count == TIMEOUT with no mem_ack: drop mem_req, load rdata of owner = 0, err=1, go to DONE.
  - err is asserted with the ack and cleared in the next cycle.
  - mem_ack in the same cycle as the timeout wins (normal completion, err=0).
- Undefined: no counter; ACC waits indefinitely; err tied 0.

## Test plan
- Reset: hold RESET_N=0 mid-ACC → mem_req, acks, err, rdata all 0 immediately; after release, IDLE with no spurious access.
- Single fetch, i_adr=0x100, memory acks in first ACC cycle with 0xC3E00000 → mem_req cycles 1..1, i_ack in cycle 2 with i_rdata=0xC3E00000, stall high cycles 0–1.
- Data write d_adr=0x40, d_wdata=0x1234ABCD, mem_ack after 4 wait cycles → mem_we=1, mem_wdata=0x1234ABCD while mem_req high; d_ack exactly one cycle.
- Tie after reset: i_req and d_req rise together and stay high → grant order fetch, data, fetch, data; no back-to-back grant to the same owner while both pend.
- Request during busy: d_req rises while a fetch is in ACC → data access starts only after DONE/IDLE; mem_adr unchanged during the fetch.
- BETA_ARB_TIMEOUT_EN, TIMEOUT=15, mem_ack never asserted → after 15 ACC cycles: mem_req=0, ack with err=1, rdata=0. Repeat with mem_ack on cycle 15 → err=0, data returned.

Source files
------------

// File: rtl/beta_mem_arbiter_if.sv
// rtl/beta_mem_arbiter_if.sv - Beta fetch/data request bus and shared memory bus bundle
interface beta_mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          i_req;
  logic [AW-1:0] i_adr;
  logic          i_ack;
  logic [DW-1:0] i_rdata;
  logic          d_req;
  logic [AW-1:0] d_adr;
  logic          d_we;
  logic [DW-1:0] d_wdata;
  logic          d_ack;
  logic [DW-1:0] d_rdata;
  logic          err;
  logic          mem_req;
  logic [AW-1:0] mem_adr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;
  logic          stall;

  modport slave (
    input  i_req, i_adr, d_req, d_adr, d_we, d_wdata, mem_ack, mem_rdata,
    output i_ack, i_rdata, d_ack, d_rdata, err, mem_req, mem_adr, mem_we, mem_wdata, stall
  );

  modport master (
    output i_req, i_adr, d_req, d_adr, d_we, d_wdata, mem_ack, mem_rdata,
    input  i_ack, i_rdata, d_ack, d_rdata, err, mem_req, mem_adr, mem_we, mem_wdata, stall
  );
endinterface

// File: rtl/beta_mem_arbiter.sv
// rtl/beta_mem_arbiter.sv - round-robin fetch/data arbiter onto one variable-latency memory
// Optional ACC watchdog enabled by defining BETA_ARB_TIMEOUT_EN.
module beta_mem_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              RESET_N,
  beta_mem_arbiter_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACC  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic OWN_FETCH = 1'b0;
  localparam logic OWN_DATA  = 1'b1;

  logic [1:0]    state;
  logic          owner;
  logic          last;
  logic          mem_req_q;
  logic          mem_we_q;
  logic [AW-1:0] mem_adr_q;
  logic [DW-1:0] mem_wdata_q;
  logic [DW-1:0] i_rdata_q;
  logic [DW-1:0] d_rdata_q;
  logic          i_ack_q;
  logic          d_ack_q;
  logic          grant_fetch;
  logic          grant_data;

  // On a tie the requester that was not served last wins.
  always_comb begin
    grant_fetch = bus.i_req & (~bus.d_req | (last == OWN_DATA));
    grant_data  = bus.d_req & ~grant_fetch;
  end

`ifdef BETA_ARB_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT + 1) > 4) ? $clog2(TIMEOUT + 1) : 4;

  logic [CW-1:0] wait_cnt;
  logic          err_q;
  logic          timeout_hit;

  // Fires in the TIMEOUT-th ACC cycle; a mem_ack in that same cycle takes priority.
  assign timeout_hit = (wait_cnt == CW'(TIMEOUT - 1)) & ~bus.mem_ack;
  assign bus.err     = err_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign bus.err        = 1'b0;
`endif

  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      state       <= S_IDLE;
      owner       <= OWN_FETCH;
      last        <= OWN_DATA;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_adr_q   <= '0;
      mem_wdata_q <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      i_ack_q     <= 1'b0;
      d_ack_q     <= 1'b0;
`ifdef BETA_ARB_TIMEOUT_EN
      wait_cnt    <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      i_ack_q <= 1'b0;
      d_ack_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (grant_fetch | grant_data) begin
            owner       <= grant_data;
            last        <= grant_data;
            mem_adr_q   <= grant_data ? bus.d_adr : bus.i_adr;
            mem_we_q    <= grant_data & bus.d_we;
            mem_wdata_q <= grant_data ? bus.d_wdata : '0;
            mem_req_q   <= 1'b1;
            state       <= S_ACC;
`ifdef BETA_ARB_TIMEOUT_EN
            wait_cnt    <= '0;
`endif
          end
        end
        S_ACC: begin
          if (bus.mem_ack) begin
            mem_req_q <= 1'b0;
            if (owner == OWN_DATA) d_rdata_q <= bus.mem_rdata;
            else                   i_rdata_q <= bus.mem_rdata;
            d_ack_q   <= (owner == OWN_DATA);
            i_ack_q   <= (owner == OWN_FETCH);
            state     <= S_DONE;
`ifdef BETA_ARB_TIMEOUT_EN
            err_q     <= 1'b0;
          end else if (timeout_hit) begin
            mem_req_q <= 1'b0;
            if (owner == OWN_DATA) d_rdata_q <= '0;
            else                   i_rdata_q <= '0;
            d_ack_q   <= (owner == OWN_DATA);
            i_ack_q   <= (owner == OWN_FETCH);
            err_q     <= 1'b1;
            state     <= S_DONE;
          end else begin
            wait_cnt  <= wait_cnt + CW'(1);
`endif
          end
        end
        S_DONE: begin
          state <= S_IDLE;
`ifdef BETA_ARB_TIMEOUT_EN
          err_q <= 1'b0;
`endif
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_adr   = mem_adr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.i_ack     = i_ack_q;
  assign bus.d_ack     = d_ack_q;
  assign bus.i_rdata   = i_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.stall     = (bus.i_req & ~i_ack_q) | (bus.d_req & ~d_ack_q);

endmodule

// File: tb/tb_beta_mem_arbiter.sv
// tb/tb_beta_mem_arbiter.sv - vector table plus scoreboard bench for beta_mem_arbiter
module tb_beta_mem_arbiter;

  logic clk = 1'b0;
  logic RESET_N;
  always #5 clk = ~clk;

  beta_mem_arbiter_if #(.AW(32), .DW(32)) bus ();

  beta_mem_arbiter #(.AW(32), .DW(32), .TIMEOUT(15)) dut (
    .clk     (clk),
    .RESET_N (RESET_N),
    .bus     (bus)
  );

  typedef struct {
    bit          own;
    logic [31:0] adr;
    bit          we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    bit          err;
  } exp_t;

  typedef struct {
    int          n_i;
    int          n_d;
    logic [31:0] ia;
    logic [31:0] da;
    bit          dwe;
    logic [31:0] dwd;
    int          wt;
    int          dly;
    string       order;
  } vec_t;

  exp_t        sb[$];
  logic [31:0] grant_log[$];
  int          checks = 0;
  int          errors = 0;
  int          mem_wait = 0;
  bit          mem_never = 1'b0;
  int          mcnt = 0;
  logic [31:0] hold_i = '0;
  logic [31:0] hold_d = '0;
  bit          prev_i = 1'b0;
  bit          prev_d = 1'b0;
  bit          prev_mreq = 1'b0;

  function automatic logic [31:0] rd_fn(logic [31:0] a);
    return (a == 32'h100) ? 32'hC3E0_0000 : {a[15:0] ^ 16'h5A5A, ~a[15:0]};
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Memory model: acks after mem_wait idle ACC cycles, never when mem_never is set.
  initial begin
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (!RESET_N) begin
        bus.mem_ack = 1'b0;
        mcnt = 0;
      end else if (bus.mem_ack) begin
        bus.mem_ack = 1'b0;
        mcnt = 0;
      end else if (bus.mem_req) begin
        if (!mem_never && mcnt >= mem_wait) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = rd_fn(bus.mem_adr);
        end else begin
          mcnt++;
        end
      end else begin
        mcnt = 0;
      end
    end
  end

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (RESET_N) begin : mon
      exp_t e;
      if (bus.mem_req && !prev_mreq) grant_log.push_back(bus.mem_adr);
      if (bus.mem_req) begin
        if (sb.size() == 0) check("mem_req_spurious", 32'd1, 32'd0);
        else begin
          check("mem_adr", bus.mem_adr, sb[0].adr);
          check("mem_we", 32'(bus.mem_we), 32'(sb[0].we));
          check("mem_wdata", bus.mem_wdata, sb[0].wdata);
        end
      end
      if (bus.i_ack && bus.d_ack) check("dual_ack", 32'd1, 32'd0);
      else if (bus.i_ack || bus.d_ack) begin
        if (sb.size() == 0) check("ack_spurious", 32'd1, 32'd0);
        else begin
          e = sb.pop_front();
          check("ack_owner", 32'(bus.d_ack), 32'(e.own));
          check("ack_err", 32'(bus.err), 32'(e.err));
          if (bus.d_ack) begin
            check("d_rdata", bus.d_rdata, e.rdata);
            check("i_rdata_hold", bus.i_rdata, hold_i);
            check("d_ack_pulse", 32'(prev_d), 32'd0);
            hold_d = e.rdata;
          end else begin
            check("i_rdata", bus.i_rdata, e.rdata);
            check("d_rdata_hold", bus.d_rdata, hold_d);
            check("i_ack_pulse", 32'(prev_i), 32'd0);
            hold_i = e.rdata;
          end
        end
      end else if (bus.err) begin
        check("err_without_ack", 32'd1, 32'd0);
      end
      prev_i    = bus.i_ack;
      prev_d    = bus.d_ack;
      prev_mreq = bus.mem_req;
    end else begin
      prev_i    = 1'b0;
      prev_d    = 1'b0;
      prev_mreq = 1'b0;
    end
  end

  task automatic do_reset();
    RESET_N     = 1'b0;
    bus.i_req   = 1'b0;
    bus.d_req   = 1'b0;
    mem_never   = 1'b0;
    sb.delete();
    hold_i = '0;
    hold_d = '0;
    repeat (2) @(negedge clk);
    RESET_N = 1'b1;
    @(negedge clk);
  endtask

  task automatic run_vec(vec_t v, string tag);
    int ci;
    int cd;
    bit done;
    exp_t e;
    ci = 0;
    cd = 0;
    done = 1'b0;
    mem_wait = v.wt;
    for (int k = 0; k < v.order.len(); k++) begin
      if (v.order[k] == "F") e = '{1'b0, v.ia, 1'b0, 32'h0, rd_fn(v.ia), 1'b0};
      else                   e = '{1'b1, v.da, v.dwe, v.dwd, rd_fn(v.da), 1'b0};
      sb.push_back(e);
    end
    bus.i_adr   = v.ia;
    bus.d_adr   = v.da;
    bus.d_we    = v.dwe;
    bus.d_wdata = v.dwd;
    bus.i_req   = (v.n_i > 0);
    bus.d_req   = (v.n_d > 0) && (v.dly == 0);
    for (int c = 0; c < 300 && !done; c++) begin
      @(negedge clk);
      if (c + 1 == v.dly && v.n_d > 0) bus.d_req = 1'b1;
      if (bus.i_ack) begin ci++; if (ci == v.n_i) bus.i_req = 1'b0; end
      if (bus.d_ack) begin cd++; if (cd == v.n_d) bus.d_req = 1'b0; end
      done = (ci == v.n_i) && (cd == v.n_d);
    end
    check({tag, "_done"}, 32'(done), 32'd1);
    if (!done) do_reset();
  endtask

`ifdef BETA_ARB_TIMEOUT_EN
  task automatic run_count(logic [31:0] a, bit never, int wt, logic [31:0] erd, bit eerr, string tag);
    int n;
    bit got;
    exp_t e;
    n = 0;
    got = 1'b0;
    mem_never = never;
    mem_wait  = wt;
    e = '{1'b0, a, 1'b0, 32'h0, erd, eerr};
    sb.push_back(e);
    bus.i_adr = a;
    bus.i_req = 1'b1;
    for (int c = 0; c < 200 && !got; c++) begin
      @(negedge clk);
      if (bus.mem_req) n++;
      if (bus.i_ack) begin got = 1'b1; bus.i_req = 1'b0; end
    end
    mem_never = 1'b0;
    check({tag, "_done"}, 32'(got), 32'd1);
    check({tag, "_acc_cycles"}, n, 32'd15);
    if (!got) do_reset();
  endtask
`endif

  vec_t vt[6];

  initial begin
    vt[0] = '{0, 1, 32'h0,   32'h40, 1'b1, 32'h1234ABCD, 4, 0, "D"};
    vt[1] = '{1, 1, 32'h200, 32'h300, 1'b0, 32'h0,        1, 0, "FD"};
    vt[2] = '{1, 1, 32'h204, 32'h44,  1'b1, 32'hCAFEF00D, 0, 0, "FD"};
    vt[3] = '{1, 0, 32'h208, 32'h0,   1'b0, 32'h0,        2, 0, "F"};
    vt[4] = '{1, 1, 32'h20C, 32'h48,  1'b0, 32'h0,        0, 0, "DF"};
    vt[5] = '{1, 1, 32'h210, 32'h4C,  1'b0, 32'h0,        3, 2, "FD"};

    RESET_N     = 1'b0;
    bus.i_req   = 1'b0;
    bus.i_adr   = '0;
    bus.d_req   = 1'b0;
    bus.d_adr   = '0;
    bus.d_we    = 1'b0;
    bus.d_wdata = '0;
    repeat (2) @(negedge clk);
    check("rst_mem_req", 32'(bus.mem_req), 32'd0);
    check("rst_i_ack", 32'(bus.i_ack), 32'd0);
    check("rst_d_ack", 32'(bus.d_ack), 32'd0);
    check("rst_i_rdata", bus.i_rdata, 32'h0);
    check("rst_mem_adr", bus.mem_adr, 32'h0);
    RESET_N = 1'b1;
    @(negedge clk);

    // Single fetch with zero-wait memory: stall/ack cycle by cycle.
    mem_wait = 0;
    sb.push_back('{1'b0, 32'h100, 1'b0, 32'h0, 32'hC3E0_0000, 1'b0});
    bus.i_adr = 32'h100;
    bus.i_req = 1'b1;
    #1;
    check("sf_c0_stall", 32'(bus.stall), 32'd1);
    check("sf_c0_mem_req", 32'(bus.mem_req), 32'd0);
    @(negedge clk);
    check("sf_c1_mem_req", 32'(bus.mem_req), 32'd1);
    check("sf_c1_stall", 32'(bus.stall), 32'd1);
    check("sf_c1_i_ack", 32'(bus.i_ack), 32'd0);
    @(negedge clk);
    check("sf_c2_i_ack", 32'(bus.i_ack), 32'd1);
    check("sf_c2_i_rdata", bus.i_rdata, 32'hC3E0_0000);
    check("sf_c2_mem_req", 32'(bus.mem_req), 32'd0);
    check("sf_c2_stall", 32'(bus.stall), 32'd0);
    bus.i_req = 1'b0;
    @(negedge clk);
    check("sf_c3_i_ack", 32'(bus.i_ack), 32'd0);

    for (int i = 0; i < 6; i++) run_vec(vt[i], $sformatf("v%0d", i));

    // Reset while a data read sits in ACC.
    mem_wait = 100;
    sb.push_back('{1'b1, 32'h60, 1'b0, 32'h0, rd_fn(32'h60), 1'b0});
    bus.d_adr = 32'h60;
    bus.d_we  = 1'b0;
    bus.d_req = 1'b1;
    repeat (3) @(negedge clk);
    check("rm_pre_mem_req", 32'(bus.mem_req), 32'd1);
    check("rm_pre_d_rdata_nz", 32'(bus.d_rdata != 32'h0), 32'd1);
    RESET_N   = 1'b0;
    bus.d_req = 1'b0;
    sb.delete();
    hold_i = '0;
    hold_d = '0;
    #1;
    check("rm_mem_req", 32'(bus.mem_req), 32'd0);
    check("rm_mem_adr", bus.mem_adr, 32'h0);
    check("rm_d_ack", 32'(bus.d_ack), 32'd0);
    check("rm_err", 32'(bus.err), 32'd0);
    check("rm_i_rdata", bus.i_rdata, 32'h0);
    check("rm_d_rdata", bus.d_rdata, 32'h0);
    repeat (2) @(negedge clk);
    RESET_N = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("rm_idle_mem_req", 32'(bus.mem_req), 32'd0);
    end

    // Tie straight after reset: fetch, data, fetch, data.
    grant_log.delete();
    run_vec('{2, 2, 32'h300, 32'h400, 1'b0, 32'h0, 0, 0, "FDFD"}, "tie");
    check("tie_grants", grant_log.size(), 32'd4);
    if (grant_log.size() == 4) begin
      check("tie_g0", grant_log[0], 32'h300);
      check("tie_g1", grant_log[1], 32'h400);
      check("tie_g2", grant_log[2], 32'h300);
      check("tie_g3", grant_log[3], 32'h400);
    end

`ifdef BETA_ARB_TIMEOUT_EN
    run_count(32'h104, 1'b1, 0, 32'h0, 1'b1, "to_never");
    run_count(32'h108, 1'b0, 14, rd_fn(32'h108), 1'b0, "to_edge");
`endif

    repeat (3) @(negedge clk);
    check("sb_drained", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule
